// File: rtl/gpu_timing_pkg.sv
// Shared raster timing constants (1080p defaults) and the position type used by
// the pixel timing generator and its counters.
package gpu_timing_pkg;

    localparam int H_ACTIVE_1080P = 1920;
    localparam int H_FP_1080P     = 88;
    localparam int H_SYNC_1080P   = 44;
    localparam int H_BP_1080P     = 148;
    localparam int V_ACTIVE_1080P = 1080;
    localparam int V_FP_1080P     = 4;
    localparam int V_SYNC_1080P   = 5;
    localparam int V_BP_1080P     = 36;

    localparam int H_TOTAL_1080P  = H_ACTIVE_1080P + H_FP_1080P + H_SYNC_1080P + H_BP_1080P;
    localparam int V_TOTAL_1080P  = V_ACTIVE_1080P + V_FP_1080P + V_SYNC_1080P + V_BP_1080P;
    localparam int HS_START_1080P = H_ACTIVE_1080P + H_FP_1080P;
    localparam int HS_END_1080P   = HS_START_1080P + H_SYNC_1080P;
    localparam int VS_START_1080P = V_ACTIVE_1080P + V_FP_1080P;
    localparam int VS_END_1080P   = VS_START_1080P + V_SYNC_1080P;

    localparam int H_CNT_W = 12;
    localparam int V_CNT_W = 11;

    typedef struct packed {
        logic [H_CNT_W-1:0] h;
        logic [V_CNT_W-1:0] v;
    } raster_pos_t;

endpackage

// File: rtl/raster_counter.sv
// Horizontal/vertical raster position counter pair with a configurable reset
// position. Exposes the next-state position so callers can register decodes in step.
module raster_counter
    import gpu_timing_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_1080P,
    parameter int V_TOTAL = V_TOTAL_1080P,
    parameter int H_INIT  = 0,
    parameter int V_INIT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [11:0] h_next,
    output logic [10:0] v_next
);

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam raster_pos_t INIT_POS = '{h: 12'(H_INIT), v: 11'(V_INIT)};

    raster_pos_t pos;
    raster_pos_t nxt;

    always_comb begin
        nxt = pos;
        if (!reset) begin
            nxt = INIT_POS;
        end else if (en) begin
            if (pos.h == H_LAST) begin
                nxt.h = '0;
                nxt.v = (pos.v == V_LAST) ? '0 : pos.v + 11'd1;
            end else begin
                nxt.h = pos.h + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        pos <= nxt;
    end

    assign h_next = nxt.h;
    assign v_next = nxt.v;

endmodule

// File: rtl/pixel_timing_gen.sv
// Free-running raster timing generator: display position with de/sync decode,
// plus a lead position running FETCH_LEAD pixels ahead for framebuffer fetch.
module pixel_timing_gen
    import gpu_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_1080P,
    parameter int H_FP       = H_FP_1080P,
    parameter int H_SYNC     = H_SYNC_1080P,
    parameter int H_BP       = H_BP_1080P,
    parameter int V_ACTIVE   = V_ACTIVE_1080P,
    parameter int V_FP       = V_FP_1080P,
    parameter int V_SYNC     = V_SYNC_1080P,
    parameter int V_BP       = V_BP_1080P,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int FETCH_LEAD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [11:0] h_cnt,
    output logic [10:0] v_cnt,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [10:0] fetch_x,
    output logic [10:0] fetch_y,
    output logic        fetch_valid
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    if (H_TOTAL > 4096 || H_ACTIVE > 2048) begin : g_bad_h_total
        $error("horizontal timing does not fit the counter widths");
    end
    if (V_TOTAL > 2048) begin : g_bad_v_total
        $error("V_TOTAL does not fit the 11-bit line counter");
    end
    if (FETCH_LEAD < 1 || FETCH_LEAD > H_TOTAL - 1) begin : g_bad_lead
        $error("FETCH_LEAD outside 1 .. H_TOTAL-1");
    end

    // Bounds are one bit wider than the counters so an end bound equal to 2^N still works.
    localparam logic [12:0] H_ACT_B   = 13'(H_ACTIVE);
    localparam logic [12:0] HS_START_B = 13'(HS_START);
    localparam logic [12:0] HS_END_B  = 13'(HS_END);
    localparam logic [11:0] V_ACT_B   = 12'(V_ACTIVE);
    localparam logic [11:0] VS_START_B = 12'(VS_START);
    localparam logic [11:0] VS_END_B  = 12'(VS_END);

    logic [11:0] main_h, lead_h;
    logic [10:0] main_v, lead_v;

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .H_INIT  (0),
        .V_INIT  (0)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .h_next (main_h),
        .v_next (main_v)
    );

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .H_INIT  (FETCH_LEAD),
        .V_INIT  (0)
    ) u_lead (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .h_next (lead_h),
        .v_next (lead_v)
    );

    logic main_h_act, main_v_act, lead_h_act, lead_v_act, main_hs, main_vs;

    assign main_h_act = {1'b0, main_h} < H_ACT_B;
    assign main_v_act = {1'b0, main_v} < V_ACT_B;
    assign lead_h_act = {1'b0, lead_h} < H_ACT_B;
    assign lead_v_act = {1'b0, lead_v} < V_ACT_B;
    assign main_hs    = ({1'b0, main_h} >= HS_START_B) && ({1'b0, main_h} < HS_END_B);
    assign main_vs    = ({1'b0, main_v} >= VS_START_B) && ({1'b0, main_v} < VS_END_B);

    // Decodes use the next-state position so every registered output matches h_cnt/v_cnt.
    always_ff @(posedge clk) begin
        h_cnt       <= main_h;
        v_cnt       <= main_v;
        x           <= main_h_act ? main_h[10:0] : '0;
        y           <= main_v_act ? main_v : '0;
        de          <= main_h_act && main_v_act;
        hsync       <= main_hs ? HS_POL : ~HS_POL;
        vsync       <= main_vs ? VS_POL : ~VS_POL;
        line_start  <= reset && en && (main_h == '0);
        frame_start <= reset && en && (main_h == '0) && (main_v == '0);
        fetch_x     <= lead_h_act ? lead_h[10:0] : '0;
        fetch_y     <= lead_v_act ? lead_v : '0;
        fetch_valid <= lead_h_act && lead_v_act;
    end

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Bench for pixel_timing_gen: a 1080p instance plus two tiny-raster instances,
// checked every cycle against a tick-count raster model and pinned by literal checks.
module tb_pixel_timing_gen;

    typedef struct packed {
        logic [11:0] h;
        logic [10:0] v;
        logic [10:0] x;
        logic [10:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [10:0] fx;
        logic [10:0] fy;
        logic        fv;
    } obs_t;

    logic clk;
    logic reset;
    logic en;

    logic [11:0] dut_h[3];
    logic [10:0] dut_v[3], dut_x[3], dut_y[3], dut_fx[3], dut_fy[3];
    logic        dut_de[3], dut_hs[3], dut_vs[3], dut_ls[3], dut_fs[3], dut_fv[3];

    int    p_ha[3]   = '{1920, 16, 16};
    int    p_hf[3]   = '{88, 2, 2};
    int    p_hsw[3]  = '{44, 3, 3};
    int    p_hb[3]   = '{148, 3, 3};
    int    p_va[3]   = '{1080, 4, 4};
    int    p_vf[3]   = '{4, 1, 1};
    int    p_vsw[3]  = '{5, 1, 1};
    int    p_vb[3]   = '{36, 1, 1};
    bit    p_hpol[3] = '{1'b1, 1'b0, 1'b1};
    bit    p_vpol[3] = '{1'b1, 1'b1, 1'b0};
    int    p_lead[3] = '{8, 1, 23};
    string inst_name[3] = '{"dfl", "smb", "smc"};

    int check_count = 0;
    int pass_count  = 0;

    int ticks       = 0;
    bit stepped     = 0;
    bit model_valid = 0;

    int dfl_ls = 0, dfl_hs = 0;
    int smb_de = 0, smb_vs = 0, smb_fs = 0, smb_ls = 0, smc_vs_low = 0;

    pixel_timing_gen u_dfl (
        .clk(clk), .reset(reset), .en(en),
        .h_cnt(dut_h[0]), .v_cnt(dut_v[0]), .x(dut_x[0]), .y(dut_y[0]),
        .de(dut_de[0]), .hsync(dut_hs[0]), .vsync(dut_vs[0]),
        .line_start(dut_ls[0]), .frame_start(dut_fs[0]),
        .fetch_x(dut_fx[0]), .fetch_y(dut_fy[0]), .fetch_valid(dut_fv[0])
    );

    pixel_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .FETCH_LEAD(1)
    ) u_smb (
        .clk(clk), .reset(reset), .en(en),
        .h_cnt(dut_h[1]), .v_cnt(dut_v[1]), .x(dut_x[1]), .y(dut_y[1]),
        .de(dut_de[1]), .hsync(dut_hs[1]), .vsync(dut_vs[1]),
        .line_start(dut_ls[1]), .frame_start(dut_fs[1]),
        .fetch_x(dut_fx[1]), .fetch_y(dut_fy[1]), .fetch_valid(dut_fv[1])
    );

    pixel_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .FETCH_LEAD(23)
    ) u_smc (
        .clk(clk), .reset(reset), .en(en),
        .h_cnt(dut_h[2]), .v_cnt(dut_v[2]), .x(dut_x[2]), .y(dut_y[2]),
        .de(dut_de[2]), .hsync(dut_hs[2]), .vsync(dut_vs[2]),
        .line_start(dut_ls[2]), .frame_start(dut_fs[2]),
        .fetch_x(dut_fx[2]), .fetch_y(dut_fy[2]), .fetch_valid(dut_fv[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The raster position is just the en-tick count since reset, taken modulo the frame size.
    function automatic obs_t model(int i, int t, bit st);
        int ht, vt, tot, p, lp, h, v, lh, lv, hss, vss;
        obs_t e;
        ht  = p_ha[i] + p_hf[i] + p_hsw[i] + p_hb[i];
        vt  = p_va[i] + p_vf[i] + p_vsw[i] + p_vb[i];
        tot = ht * vt;
        p   = t % tot;
        lp  = (t + p_lead[i]) % tot;
        h   = p % ht;
        v   = p / ht;
        lh  = lp % ht;
        lv  = lp / ht;
        hss = p_ha[i] + p_hf[i];
        vss = p_va[i] + p_vf[i];
        e.h  = 12'(h);
        e.v  = 11'(v);
        e.x  = (h < p_ha[i]) ? 11'(h) : 11'd0;
        e.y  = (v < p_va[i]) ? 11'(v) : 11'd0;
        e.de = (h < p_ha[i]) && (v < p_va[i]);
        e.hs = (h >= hss && h < hss + p_hsw[i]) ? p_hpol[i] : !p_hpol[i];
        e.vs = (v >= vss && v < vss + p_vsw[i]) ? p_vpol[i] : !p_vpol[i];
        e.ls = st && (h == 0);
        e.fs = st && (h == 0) && (v == 0);
        e.fx = (lh < p_ha[i]) ? 11'(lh) : 11'd0;
        e.fy = (lv < p_va[i]) ? 11'(lv) : 11'd0;
        e.fv = (lh < p_ha[i]) && (lv < p_va[i]);
        return e;
    endfunction

    function automatic obs_t actual(int i);
        obs_t a;
        a.h  = dut_h[i];
        a.v  = dut_v[i];
        a.x  = dut_x[i];
        a.y  = dut_y[i];
        a.de = dut_de[i];
        a.hs = dut_hs[i];
        a.vs = dut_vs[i];
        a.ls = dut_ls[i];
        a.fs = dut_fs[i];
        a.fx = dut_fx[i];
        a.fy = dut_fy[i];
        a.fv = dut_fv[i];
        return a;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic checkOutput(input string tag, input obs_t a, input obs_t e);
        checkField({tag, ".h_cnt"}, a.h, e.h);
        checkField({tag, ".v_cnt"}, a.v, e.v);
        checkField({tag, ".x"}, a.x, e.x);
        checkField({tag, ".y"}, a.y, e.y);
        checkField({tag, ".de"}, a.de, e.de);
        checkField({tag, ".hsync"}, a.hs, e.hs);
        checkField({tag, ".vsync"}, a.vs, e.vs);
        checkField({tag, ".line_start"}, a.ls, e.ls);
        checkField({tag, ".frame_start"}, a.fs, e.fs);
        checkField({tag, ".fetch_x"}, a.fx, e.fx);
        checkField({tag, ".fetch_y"}, a.fy, e.fy);
        checkField({tag, ".fetch_valid"}, a.fv, e.fv);
    endtask

    task automatic applyStimulus(input logic rst_n, input logic en_val, input int cycles);
        reset = rst_n;
        en    = en_val;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic pinResetState(input string tag);
        checkField({tag, ".h_cnt"}, dut_h[0], 0);
        checkField({tag, ".v_cnt"}, dut_v[0], 0);
        checkField({tag, ".x"}, dut_x[0], 0);
        checkField({tag, ".de"}, dut_de[0], 1);
        checkField({tag, ".hsync"}, dut_hs[0], 0);
        checkField({tag, ".line_start"}, dut_ls[0], 0);
        checkField({tag, ".frame_start"}, dut_fs[0], 0);
        checkField({tag, ".fetch_x"}, dut_fx[0], 8);
        checkField({tag, ".fetch_y"}, dut_fy[0], 0);
        checkField({tag, ".fetch_valid"}, dut_fv[0], 1);
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            ticks       <= 0;
            stepped     <= 1'b0;
            model_valid <= 1'b1;
        end else if (en) begin
            ticks   <= ticks + 1;
            stepped <= 1'b1;
        end else begin
            stepped <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 3; i++) checkOutput(inst_name[i], actual(i), model(i, ticks, stepped));
            dfl_ls     <= dfl_ls + int'(dut_ls[0]);
            dfl_hs     <= dfl_hs + int'(dut_hs[0]);
            smb_de     <= smb_de + int'(dut_de[1]);
            smb_vs     <= smb_vs + int'(dut_vs[1]);
            smb_fs     <= smb_fs + int'(dut_fs[1]);
            smb_ls     <= smb_ls + int'(dut_ls[1]);
            smc_vs_low <= smc_vs_low + int'(!dut_vs[2]);
        end
    end

    initial begin
        int s_ls, s_hs, s_de, s_vs, s_fs, s_sls, s_cvs;
        reset = 1'b0;
        en    = 1'b1;

        applyStimulus(1'b0, 1'b1, 3);
        pinResetState("pin.reset_initial");
        checkField("pin.smb_reset_hsync", dut_hs[1], 1);
        checkField("pin.smb_reset_fetch_x", dut_fx[1], 1);
        checkField("pin.smc_reset_fetch_x", dut_fx[2], 0);
        checkField("pin.smc_reset_fetch_valid", dut_fv[2], 0);
        checkField("pin.smc_reset_vsync", dut_vs[2], 1);

        @(negedge clk); #1;
        s_ls = dfl_ls;
        s_hs = dfl_hs;
        applyStimulus(1'b1, 1'b1, 2200);
        checkField("pin.line_wrap_h", dut_h[0], 0);
        checkField("pin.line_wrap_v", dut_v[0], 1);
        checkField("pin.line_wrap_line_start", dut_ls[0], 1);
        checkField("pin.line_wrap_frame_start", dut_fs[0], 0);
        @(negedge clk); #1;
        checkField("cnt.dfl_line_starts", dfl_ls - s_ls, 1);
        checkField("cnt.dfl_hsync_cycles", dfl_hs - s_hs, 44);

        for (int i = 0; i < 60; i++) applyStimulus(1'b1, (i % 2) == 0, 1);
        checkField("pin.toggle_h", dut_h[0], 30);
        checkField("pin.toggle_v", dut_v[0], 1);

        applyStimulus(1'b1, 1'b1, 1470);
        checkField("pin.mid_h", dut_h[0], 1500);
        applyStimulus(1'b0, 1'b1, 1);
        pinResetState("pin.reset_mid_en1");
        applyStimulus(1'b1, 1'b1, 1500);
        checkField("pin.mid2_h", dut_h[0], 1500);
        applyStimulus(1'b0, 1'b0, 1);
        pinResetState("pin.reset_mid_en0");

        @(negedge clk); #1;
        s_de  = smb_de;
        s_vs  = smb_vs;
        s_fs  = smb_fs;
        s_sls = smb_ls;
        s_cvs = smc_vs_low;
        applyStimulus(1'b1, 1'b1, 168);
        checkField("pin.smb_frame_start", dut_fs[1], 1);
        checkField("pin.smb_frame_h", dut_h[1], 0);
        checkField("pin.smb_frame_v", dut_v[1], 0);
        checkField("pin.smc_frame_start", dut_fs[2], 1);
        @(negedge clk); #1;
        checkField("cnt.smb_de_cycles", smb_de - s_de, 64);
        checkField("cnt.smb_vsync_cycles", smb_vs - s_vs, 24);
        checkField("cnt.smb_frame_starts", smb_fs - s_fs, 1);
        checkField("cnt.smb_line_starts", smb_ls - s_sls, 7);
        checkField("cnt.smc_vsync_low_cycles", smc_vs_low - s_cvs, 24);

        applyStimulus(1'b1, 1'b1, 17);
        checkField("pin.smb_h17_hsync", dut_hs[1], 1);
        applyStimulus(1'b1, 1'b1, 1);
        checkField("pin.smb_h18_hsync", dut_hs[1], 0);
        applyStimulus(1'b1, 1'b1, 2);
        checkField("pin.smb_h20_hsync", dut_hs[1], 0);
        applyStimulus(1'b1, 1'b1, 1);
        checkField("pin.smb_h21_hsync", dut_hs[1], 1);

        applyStimulus(1'b1, 1'b1, 400);
        @(negedge clk); #1;

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
